// File: rtl/mod_vector_arbiter_pkg.sv
// Shared types and constants for the modular vector datapath.
// wide_vec_t carries unreduced signed slots from any producer into the reducer.
package mod_vector_arbiter_pkg;

  localparam int unsigned N_SLOTS_L = 8;
  localparam int unsigned W_BITS_L  = 16;
  localparam int unsigned WW_BITS_L = 2 * W_BITS_L;
  localparam int unsigned Q_MOD_L   = 7710;

  typedef logic [W_BITS_L-1:0]         word_t;
  typedef word_t [N_SLOTS_L-1:0]       vec_t;
  typedef logic signed [WW_BITS_L-1:0] wide_word_t;
  typedef wide_word_t [N_SLOTS_L-1:0]  wide_vec_t;

  // Width of a requester index; at least one bit so single-bit fields stay legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_vector_arbiter_if.sv
// Requester and result bundle of the shared reducer arbiter.
// slave is the arbiter side; master is the requester/consumer side.
interface mod_vector_arbiter_if
  import mod_vector_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SW   = sel_width(NREQ)
);

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  wide_vec_t       req_vec [NREQ];
  logic            out_valid;
  logic            out_ready;
  vec_t            out_vec;
  logic [SW-1:0]   out_src;

  modport slave (
    input  req_valid, req_vec, out_ready,
    output req_ready, out_valid, out_vec, out_src
  );

  modport master (
    output req_valid, req_vec, out_ready,
    input  req_ready, out_valid, out_vec, out_src
  );

endinterface

// File: rtl/mod_vector_arbiter_mod_vector.sv
// Combinational per-slot reduction of signed wide words into [0, Q).
module mod_vector
  import mod_vector_arbiter_pkg::*;
(
  input  wide_vec_t raw,
  output vec_t      res
);

  localparam wide_word_t QS = wide_word_t'(Q_MOD_L);

  wide_word_t rem;

  always_comb begin
    res = '0;
    rem = '0;
    for (int unsigned s = 0; s < N_SLOTS_L; s++) begin
      // Signed % keeps the dividend's sign; fold negatives back into range.
      rem = $signed(raw[s]) % QS;
      if (rem < 0) begin
        rem = rem + QS;
      end
      res[s] = rem[W_BITS_L-1:0];
    end
  end

endmodule

// File: rtl/mod_vector_arbiter.sv
// Round-robin arbiter sharing one mod_vector reducer among NREQ requesters.
// Result is registered one cycle after transfer and tagged with its source index.
module mod_vector_arbiter
  import mod_vector_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned SW   = sel_width(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  mod_vector_arbiter_if.slave bus
);

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] valid,
                                          input logic [SW-1:0]   ptr);
    logic [SW:0]   res;
    logic [SW-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = SW'((32'(ptr) + k) % NREQ);
      if (!res[SW] && valid[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic          load;
  logic [SW:0]   pick;
  logic          grant_found;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] next_ptr;
  wide_vec_t     sel_vec;
  vec_t          reduced;

  logic          out_valid_q;
  vec_t          out_vec_q;
  logic [SW-1:0] out_src_q;
  logic [SW-1:0] rr_ptr_q;

  assign load        = !out_valid_q || bus.out_ready;
  assign pick        = rr_pick(bus.req_valid, rr_ptr_q);
  assign grant_found = pick[SW] && load && !rst;
  assign grant_idx   = pick[SW-1:0];
  assign next_ptr    = (grant_idx == SW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign sel_vec     = bus.req_vec[grant_idx];

  always_comb begin
    bus.req_ready = '0;
    if (grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  mod_vector u_mod_vector (
    .raw (sel_vec),
    .res (reduced)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (load) begin
      // Result and source only move on a transfer so they stay put otherwise.
      out_valid_q <= grant_found;
      if (grant_found) begin
        out_vec_q <= reduced;
        out_src_q <= grant_idx;
        rr_ptr_q  <= next_ptr;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_mod_vector_arbiter.sv
// Bench for mod_vector_arbiter: directed reset/grant/backpressure cases, then a
// random soak checked by a golden-model scoreboard and a round-robin ready model.
module tb_mod_vector_arbiter;
  import mod_vector_arbiter_pkg::*;

  typedef struct {
    logic src;
    vec_t vec;
  } exp_t;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  exp_t       sb [$];
  exp_t       ent;
  logic       started;
  logic       tb_ptr;
  logic [1:0] xfer_last;
  logic [1:0] exp_rdy;
  logic       ld;
  logic       have_prev;
  logic [1:0] prev_valid;
  logic [1:0] prev_xfer;
  wide_vec_t  prev_vec [2];

  wide_vec_t  va_vec;
  wide_vec_t  vb_vec;
  vec_t       ea_vec;
  wide_vec_t  rv;
  logic       g;

  mod_vector_arbiter_if #(.NREQ(2)) bus ();

  mod_vector_arbiter #(.NREQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t golden(input wide_vec_t v);
    longint x;
    longint q;
    vec_t   r;
    q = longint'(Q_MOD_L);
    for (int s = 0; s < int'(N_SLOTS_L); s++) begin
      x    = longint'($signed(v[s]));
      r[s] = word_t'(((x % q) + q) % q);
    end
    return r;
  endfunction

  function automatic logic [1:0] model_ready(input logic [1:0] v, input logic p);
    if (v[p]) return 2'b01 << p;
    if (v[~p]) return 2'b01 << (~p);
    return 2'b00;
  endfunction

  task automatic rand_vec(output wide_vec_t v);
    for (int s = 0; s < int'(N_SLOTS_L); s++) begin
      case ($urandom_range(0, 3))
        0: v[s] = wide_word_t'($urandom());
        1: v[s] = wide_word_t'(int'($urandom_range(0, 40000)) - 20000);
        2: v[s] = wide_word_t'(int'(Q_MOD_L) * (int'($urandom_range(0, 20)) - 10)
                              + int'($urandom_range(0, 2)) - 1);
        default: v[s] = ($urandom_range(0, 1) == 0) ? 32'sh8000_0000 : 32'sh7fff_ffff;
      endcase
    end
  endtask

  // Monitor: ready model, requester stability rule, and result scoreboard.
  always @(posedge clk) begin
    if (rst) begin
      if (started) check("rst_ready", bus.req_ready, 2'b00);
      sb.delete();
      tb_ptr    = 1'b0;
      started   = 1'b1;
      xfer_last = 2'b00;
      have_prev = 1'b0;
    end else if (started) begin
      ld      = !bus.out_valid || bus.out_ready;
      exp_rdy = ld ? model_ready(bus.req_valid, tb_ptr) : 2'b00;
      check("req_ready", bus.req_ready, exp_rdy);
      for (int i = 0; i < 2; i++) begin
        if (have_prev && prev_valid[i] && !prev_xfer[i]) begin
          check("hold_valid", bus.req_valid[i], 1'b1);
          check("hold_vec", bus.req_vec[i], prev_vec[i]);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_spurious", 1'b1, 1'b0);
        end else begin
          ent = sb.pop_front();
          check("sb_src", bus.out_src, ent.src);
          check("sb_vec", bus.out_vec, ent.vec);
        end
      end
      xfer_last = bus.req_valid & bus.req_ready;
      for (int i = 0; i < 2; i++) begin
        if (xfer_last[i]) begin
          sb.push_back('{src: 1'(i), vec: golden(bus.req_vec[i])});
          tb_ptr = ~1'(i);
        end
      end
      have_prev  = 1'b1;
      prev_valid = bus.req_valid;
      prev_xfer  = xfer_last;
      prev_vec   = bus.req_vec;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int va [8];
    int ea [8];
    tests_run    = 0;
    tests_failed = 0;
    started      = 1'b0;
    va = '{-1, -20, 0, 5, 7709, 7710, 7711, 9041};
    ea = '{7709, 7690, 0, 5, 7709, 0, 1, 1331};
    for (int s = 0; s < 8; s++) begin
      va_vec[s] = wide_word_t'(va[s]);
      vb_vec[s] = -32'sd7710;
      ea_vec[s] = word_t'(ea[s]);
    end

    // Reset held with both requesters valid.
    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_vec[0] = va_vec;
    bus.req_vec[1] = vb_vec;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_ready_rst", bus.req_ready, 2'b00);
    check("t1_valid_rst", bus.out_valid, 1'b0);
    check("t1_vec_rst", bus.out_vec, '0);
    check("t1_src_rst", bus.out_src, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_grant", bus.req_ready, 2'b01);

    // Single transfer from req0 with boundary slot values.
    @(posedge clk); #1;
    check("t2_valid", bus.out_valid, 1'b1);
    check("t2_src", bus.out_src, 1'b0);
    check("t2_vec", bus.out_vec, ea_vec);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("t2_ready_r1", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    check("t2_src1", bus.out_src, 1'b1);
    check("t2_vec1", bus.out_vec, '0);

    // Contention: grants alternate starting with req0.
    bus.req_valid = 2'b11;
    g = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_ready", bus.req_ready, 2'b01 << g);
      @(posedge clk); #1;
      check("t3_src", bus.out_src, g);
      check("t3_vec", bus.out_vec, g ? vec_t'('0) : ea_vec);
      g = ~g;
    end

    // Backpressure with req0's result pending.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_ready_stall", bus.req_ready, 2'b00);
      @(posedge clk); #1;
      check("t4_valid_hold", bus.out_valid, 1'b1);
      check("t4_src_hold", bus.out_src, 1'b0);
      check("t4_vec_hold", bus.out_vec, ea_vec);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_resume_grant", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    check("t4_resume_src", bus.out_src, 1'b1);
    @(posedge clk); #1;
    check("t4_next_src", bus.out_src, 1'b0);

    // Reset mid-operation discards the pending result and rewinds the pointer.
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    check("t5_ready_rst", bus.req_ready, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_valid_cleared", bus.out_valid, 1'b0);
    check("t5_vec_cleared", bus.out_vec, '0);
    @(negedge clk);
    check("t5_grant_after_rst", bus.req_ready, 2'b01);
    @(posedge clk); #1;
    check("t5_src", bus.out_src, 1'b0);
    check("t5_valid", bus.out_valid, 1'b1);

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] || xfer_last[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          rand_vec(rv);
          bus.req_vec[i] = rv;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    // Drain: requesters retire once served, consumer always ready.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (xfer_last[i]) bus.req_valid[i] = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("sb_drain_left", 128'(sb.size()), 128'd0);
    check("drain_valid", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
